// File: rtl/eq_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eq_sequencer                                                 |
// | Description : Request-side sequencer for the shared-multiplier equation    |
// |               datapath (A = 3*x1 + 5*x2, B = v*t + c). It accepts one      |
// |               request at a time, holds the operands stable towards the     |
// |               datapath, waits a fixed latency, then captures the selected  |
// |               result and returns it over a valid/ready handshake.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eq_sequencer #(
  parameter int DW       = 8,
  parameter int RW       = 16,
  parameter int CTRL_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  // upstream request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_sel,
  input  logic [DW-1:0] req_x1,
  input  logic [DW-1:0] req_x2,
  input  logic [DW-1:0] req_v,
  input  logic [DW-1:0] req_t,
  input  logic [DW-1:0] req_c,
  // datapath operand side
  output logic [DW-1:0] ctrl_x1,
  output logic [DW-1:0] ctrl_x2,
  output logic [DW-1:0] ctrl_v,
  output logic [DW-1:0] ctrl_t,
  output logic [DW-1:0] ctrl_c,
  output logic          ctrl_eqflag,
  input  logic [RW-1:0] ctrl_a,
  input  logic [RW-1:0] ctrl_b,
  // downstream response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_sel,
  output logic [RW-1:0] rsp_data,
  // status
  output logic          busy,
  output logic [7:0]    done_cnt
);

  // Wait counter preload: the ISSUE edge already accounts for one datapath edge.
  localparam logic [3:0] c_WCNT_LOAD = 4'(CTRL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [3:0]    r_wcnt;

  logic [DW-1:0] r_x1;
  logic [DW-1:0] r_x2;
  logic [DW-1:0] r_v;
  logic [DW-1:0] r_t;
  logic [DW-1:0] r_c;
  logic          r_eqflag;

  logic          r_rsp_sel;
  logic [RW-1:0] r_rsp_data;
  logic [7:0]    r_done_cnt;

  // per-cycle control strobes decoded from the current state
  logic          w_accept;
  logic          w_load_cnt;
  logic          w_dec_cnt;
  logic          w_capture;
  logic          w_retire;
  logic          w_req_ready;
  logic          w_rsp_valid;
  logic          w_busy;

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and control strobes; handshake outputs depend on state only.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_cnt  = 1'b0;
    w_dec_cnt   = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_load_cnt  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wcnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_dec_cnt   = 1'b1;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latency counter: preloaded on the ISSUE edge, counts down while waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt <= 4'd0;
    end else if (w_load_cnt) begin
      r_wcnt <= c_WCNT_LOAD;
    end else if (w_dec_cnt) begin
      r_wcnt <= r_wcnt - 4'd1;
    end
  end

  // Operand registers: loaded only on an accepting edge so the datapath inputs,
  // including the unselected equation's operands, stay frozen while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x1     <= '0;
      r_x2     <= '0;
      r_v      <= '0;
      r_t      <= '0;
      r_c      <= '0;
      r_eqflag <= 1'b0;
    end else if (w_accept) begin
      r_x1     <= req_x1;
      r_x2     <= req_x2;
      r_v      <= req_v;
      r_t      <= req_t;
      r_c      <= req_c;
      r_eqflag <= req_sel;
    end
  end

  // Response capture: selected result is sampled once and held until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_sel  <= 1'b0;
      r_rsp_data <= '0;
    end else if (w_capture) begin
      r_rsp_sel  <= r_eqflag;
      r_rsp_data <= r_eqflag ? ctrl_a : ctrl_b;
    end
  end

  // Completed-response counter, wraps silently at 8 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done_cnt <= 8'd0;
    end else if (w_retire) begin
      r_done_cnt <= r_done_cnt + 8'd1;
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = w_rsp_valid;
  assign busy        = w_busy;

  assign ctrl_x1     = r_x1;
  assign ctrl_x2     = r_x2;
  assign ctrl_v      = r_v;
  assign ctrl_t      = r_t;
  assign ctrl_c      = r_c;
  assign ctrl_eqflag = r_eqflag;

  assign rsp_sel     = r_rsp_sel;
  assign rsp_data    = r_rsp_data;
  assign done_cnt    = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eq_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eq_sequencer                                              |
// | Description : Bench for eq_sequencer. Two instances (CTRL_LAT=1 and 3)     |
// |               share one stimulus stream; each has its own transaction-     |
// |               level reference model and a behavioural equation datapath.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_eq_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic       rst_n;
  logic       req_valid;
  logic       req_sel;
  logic [7:0] req_x1, req_x2, req_v, req_t, req_c;
  logic       rsp_ready;

  // per-instance outputs (index 0: CTRL_LAT=1, index 1: CTRL_LAT=3)
  logic [1:0]       req_ready, busy, rsp_valid, rsp_sel, ctrl_eqflag;
  logic [1:0][7:0]  ctrl_x1, ctrl_x2, ctrl_v, ctrl_t, ctrl_c, done_cnt;
  logic [1:0][15:0] ctrl_a, ctrl_b, rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [15:0] f_eq_a(input logic [7:0] x1, input logic [7:0] x2);
    return 16'(x1) * 16'd3 + 16'(x2) * 16'd5;
  endfunction

  function automatic logic [15:0] f_eq_b(input logic [7:0] v, input logic [7:0] t, input logic [7:0] c);
    return 16'(v) * 16'(t) + 16'(c);
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // behavioural datapath fed by each sequencer's operand outputs
  assign ctrl_a[0] = f_eq_a(ctrl_x1[0], ctrl_x2[0]);
  assign ctrl_b[0] = f_eq_b(ctrl_v[0], ctrl_t[0], ctrl_c[0]);
  assign ctrl_a[1] = f_eq_a(ctrl_x1[1], ctrl_x2[1]);
  assign ctrl_b[1] = f_eq_b(ctrl_v[1], ctrl_t[1], ctrl_c[1]);

  eq_sequencer #(.DW(8), .RW(16), .CTRL_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_sel(req_sel),
    .req_x1(req_x1), .req_x2(req_x2), .req_v(req_v), .req_t(req_t), .req_c(req_c),
    .ctrl_x1(ctrl_x1[0]), .ctrl_x2(ctrl_x2[0]), .ctrl_v(ctrl_v[0]), .ctrl_t(ctrl_t[0]),
    .ctrl_c(ctrl_c[0]), .ctrl_eqflag(ctrl_eqflag[0]), .ctrl_a(ctrl_a[0]), .ctrl_b(ctrl_b[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_sel(rsp_sel[0]), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .done_cnt(done_cnt[0])
  );

  eq_sequencer #(.DW(8), .RW(16), .CTRL_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_sel(req_sel),
    .req_x1(req_x1), .req_x2(req_x2), .req_v(req_v), .req_t(req_t), .req_c(req_c),
    .ctrl_x1(ctrl_x1[1]), .ctrl_x2(ctrl_x2[1]), .ctrl_v(ctrl_v[1]), .ctrl_t(ctrl_t[1]),
    .ctrl_c(ctrl_c[1]), .ctrl_eqflag(ctrl_eqflag[1]), .ctrl_a(ctrl_a[1]), .ctrl_b(ctrl_b[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_sel(rsp_sel[1]), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .done_cnt(done_cnt[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: actual 0x%0h required 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A request taken while free completes its capture lat+1 edges after the
  // accepting edge; the result is then offered until the consumer takes it.
  logic        m_init = 1'b0;
  logic        m_busy [2];
  logic        m_resp [2];
  int          m_age  [2];
  logic [7:0]  m_x1 [2], m_x2 [2], m_v [2], m_t [2], m_c [2];
  logic        m_sel  [2];
  logic        m_rsel [2];
  logic [15:0] m_rdata[2];
  logic [7:0]  m_done [2];
  int          m_total[2] = '{0, 0};

  always @(posedge clk) begin
    m_init <= m_init | !rst_n;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_busy[d] <= 1'b0; m_resp[d] <= 1'b0; m_age[d] <= 0;
        m_x1[d] <= '0; m_x2[d] <= '0; m_v[d] <= '0; m_t[d] <= '0; m_c[d] <= '0;
        m_sel[d] <= 1'b0; m_rsel[d] <= 1'b0; m_rdata[d] <= '0; m_done[d] <= '0;
      end else if (!m_busy[d]) begin
        if (req_valid) begin
          m_busy[d] <= 1'b1; m_age[d] <= 0;
          m_x1[d] <= req_x1; m_x2[d] <= req_x2; m_v[d] <= req_v; m_t[d] <= req_t; m_c[d] <= req_c;
          m_sel[d] <= req_sel;
        end
      end else if (m_resp[d]) begin
        if (rsp_ready) begin
          m_busy[d]  <= 1'b0;
          m_resp[d]  <= 1'b0;
          m_done[d]  <= m_done[d] + 8'd1;
          m_total[d] <= m_total[d] + 1;
        end
      end else begin
        m_age[d] <= m_age[d] + 1;
        if (m_age[d] == lat_of(d)) begin
          m_resp[d]  <= 1'b1;
          m_rsel[d]  <= m_sel[d];
          m_rdata[d] <= m_sel[d] ? f_eq_a(m_x1[d], m_x2[d]) : f_eq_b(m_v[d], m_t[d], m_c[d]);
        end
      end
    end
  end

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_init) begin
      for (int d = 0; d < 2; d++) begin
        chk("req_ready",   d, 32'(req_ready[d]),   32'(!m_busy[d]));
        chk("busy",        d, 32'(busy[d]),        32'(m_busy[d]));
        chk("rsp_valid",   d, 32'(rsp_valid[d]),   32'(m_resp[d]));
        chk("rsp_sel",     d, 32'(rsp_sel[d]),     32'(m_rsel[d]));
        chk("rsp_data",    d, 32'(rsp_data[d]),    32'(m_rdata[d]));
        chk("done_cnt",    d, 32'(done_cnt[d]),    32'(m_done[d]));
        chk("ctrl_x1",     d, 32'(ctrl_x1[d]),     32'(m_x1[d]));
        chk("ctrl_x2",     d, 32'(ctrl_x2[d]),     32'(m_x2[d]));
        chk("ctrl_v",      d, 32'(ctrl_v[d]),      32'(m_v[d]));
        chk("ctrl_t",      d, 32'(ctrl_t[d]),      32'(m_t[d]));
        chk("ctrl_c",      d, 32'(ctrl_c[d]),      32'(m_c[d]));
        chk("ctrl_eqflag", d, 32'(ctrl_eqflag[d]), 32'(m_sel[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int i;
    i = 0;
    while (req_ready != 2'b11 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", 0, 32'(req_ready), 32'h3);
  endtask

  task automatic set_ops(input logic sel, input logic [7:0] x1, input logic [7:0] x2,
                         input logic [7:0] v, input logic [7:0] t, input logic [7:0] c);
    req_sel = sel; req_x1 = x1; req_x2 = x2; req_v = v; req_t = t; req_c = c;
  endtask

  task automatic send(input logic sel, input logic [7:0] x1, input logic [7:0] x2,
                      input logic [7:0] v, input logic [7:0] t, input logic [7:0] c);
    set_ops(sel, x1, x2, v, t, c);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rand_ops();
    set_ops(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    int first0, first1, base, i;
    logic [15:0] d0;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    set_ops(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    // reset held for two edges
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("reset_busy",      0, 32'(busy[0]),      32'd0);
    chk("reset_rsp_data",  1, 32'(rsp_data[1]),  32'd0);
    rst_n = 1'b1;

    // equation A: 3*2 + 5*4 = 0x001A, visible after the second edge following accept
    rsp_ready = 1'b1;
    wait_idle();
    send(1'b1, 8'd2, 8'd4, 8'd11, 8'd12, 8'd13);
    @(negedge clk);
    chk("a_not_yet_valid", 0, 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    chk("a_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
    chk("a_rsp_data",  0, 32'(rsp_data[0]),  32'h001A);
    chk("a_rsp_sel",   0, 32'(rsp_sel[0]),   32'd1);
    @(negedge clk);
    chk("a_done_cnt",  0, 32'(done_cnt[0]),  32'd1);

    // equation B: 6*7 + 5 = 0x002F; A output stays at 3*9 + 5*1 = 0x0020
    wait_idle();
    send(1'b0, 8'd9, 8'd1, 8'd6, 8'd7, 8'd5);
    first0 = 0; first1 = 0; d0 = '0;
    for (int k = 1; k <= 20; k++) begin
      chk("b_ctrl_a_stable", 0, 32'(ctrl_a[0]), 32'h0020);
      if (rsp_valid[0] && first0 == 0) begin first0 = k - 1; d0 = rsp_data[0]; end
      if (rsp_valid[1] && first1 == 0) first1 = k - 1;
      if (first0 != 0 && first1 != 0) break;
      @(negedge clk);
    end
    chk("b_lat1_edges", 0, 32'(first0), 32'd2);
    chk("b_lat3_edges", 1, 32'(first1), 32'd4);
    chk("b_rsp_data",   0, 32'(d0),     32'h002F);

    // backpressure: first request 3*10 + 5*20 = 0x0082 held, second (3*4 + 1) waits
    wait_idle();
    rsp_ready = 1'b0;
    set_ops(1'b1, 8'd10, 8'd20, 8'd0, 8'd0, 8'd0);
    req_valid = 1'b1;
    @(negedge clk);
    set_ops(1'b0, 8'd99, 8'd98, 8'd3, 8'd4, 8'd1);
    repeat (12) @(negedge clk);
    chk("bp_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
    chk("bp_req_ready", 0, 32'(req_ready[0]), 32'd0);
    chk("bp_rsp_data",  0, 32'(rsp_data[0]),  32'h0082);
    chk("bp_ctrl_x1",   0, 32'(ctrl_x1[0]),   32'd10);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 0, 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_second_accepted", 0, 32'(ctrl_v[0]), 32'd3);
    i = 0;
    while (!rsp_valid[0] && i < 20) begin @(negedge clk); i++; end
    chk("bp_second_data", 0, 32'(rsp_data[0]), 32'h000D);

    // reset while waiting for the datapath
    wait_idle();
    send(1'b1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rst_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);
      @(negedge clk);
    end
    chk("rst_done_cnt", 0, 32'(done_cnt[0]), 32'd0);

    // back-to-back stream until the CTRL_LAT=3 counter wraps after 256 responses
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    base = m_total[1];
    i = 0;
    while (m_total[1] != base + 256 && i < 4000) begin
      rand_ops();
      @(negedge clk);
      i++;
    end
    req_valid = 1'b0;
    chk("wrap_done_cnt", 1, 32'(done_cnt[1]), 32'd0);
    chk("wrap_count",    1, 32'(m_total[1] - base), 32'd256);

    // random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      rand_ops();
      req_valid = ($urandom_range(0, 1) == 1);
      rsp_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
